// File: rtl/bringup_sequencer_if.sv
// Handshake bundle between the bring-up sequencer and its per-channel init/read engines.
// The master side is the sequencer; the slave side is the engines plus the read requester.
interface bringup_sequencer_if #(
   parameter int NUM_CHAN = 2
);
   logic [NUM_CHAN-1:0] init_start;
   logic [NUM_CHAN-1:0] init_done;
   logic                rd_req;
   logic [2:0]          rd_sel;
   logic [NUM_CHAN-1:0] rd_start;
   logic [NUM_CHAN-1:0] rd_done;
   logic                busy;
   logic                all_ready;
   logic [NUM_CHAN-1:0] fail;
   logic                rd_err;
   logic [2:0]          cur_chan;
   logic [3:0]          state_out;

   modport master (
      output init_start, rd_start, busy, all_ready, fail, rd_err, cur_chan, state_out,
      input  init_done, rd_req, rd_sel, rd_done
   );

   modport slave (
      input  init_start, rd_start, busy, all_ready, fail, rd_err, cur_chan, state_out,
      output init_done, rd_req, rd_sel, rd_done
   );
endinterface

// File: rtl/bringup_sequencer.sv
// Power-up sequencer: startup hold-off, ordered per-channel init with settle/timeout/retry,
// then on-demand per-channel register reads. All outputs are registered.
module bringup_sequencer #(
   parameter int          NUM_CHAN      = 2,
   parameter logic [31:0] STARTUP_DELAY = 32'd1000000,
   parameter logic [31:0] SETTLE_DELAY  = 32'd1000,
   parameter logic [31:0] INIT_TIMEOUT  = 32'd20000,
   parameter logic [3:0]  MAX_RETRY     = 4'd2,
   parameter logic [31:0] RD_TIMEOUT    = 32'd600
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_1us,
   bringup_sequencer_if.master  bus
);

   typedef enum logic [3:0] {
      S_READY      = 4'd0,
      S_STARTUP    = 4'd1,
      S_INIT_START = 4'd2,
      S_INIT_WAIT  = 4'd3,
      S_RD_START   = 4'd4,
      S_RD_WAIT    = 4'd5,
      S_NEXT       = 4'd6
   } state_t;

   localparam logic [3:0] NUM_CHAN_W = 4'(NUM_CHAN);
   localparam logic [2:0] LAST_CHAN  = 3'(NUM_CHAN - 1);

   // Index-to-one-hot without out-of-range vector indexing.
   function automatic logic [NUM_CHAN-1:0] chan_onehot(input logic [2:0] idx);
      logic [NUM_CHAN-1:0] oh;
      for (int i = 0; i < NUM_CHAN; i++) begin
         oh[i] = (idx == i[2:0]);
      end
      return oh;
   endfunction

   state_t              state_q, state_d;
   logic [31:0]         cnt_q, cnt_d;
   logic [2:0]          cur_chan_q, cur_chan_d;
   logic [3:0]          retry_q, retry_d;
   logic [NUM_CHAN-1:0] fail_q, fail_d;
   logic [NUM_CHAN-1:0] init_start_q, init_start_d;
   logic [NUM_CHAN-1:0] rd_start_q, rd_start_d;
   logic                rd_err_q, rd_err_d;
   logic                busy_q, busy_d;
   logic                all_ready_q, all_ready_d;

   logic [NUM_CHAN-1:0] cur_oh_s;
   logic                init_done_sel_s;
   logic                rd_done_sel_s;
   logic                rd_ok_s;

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d      = state_q;
      cur_chan_d   = cur_chan_q;
      retry_d      = retry_q;
      fail_d       = fail_q;
      rd_err_d     = 1'b0;

      cur_oh_s        = chan_onehot(cur_chan_q);
      init_done_sel_s = |(bus.init_done & cur_oh_s);
      rd_done_sel_s   = |(bus.rd_done & cur_oh_s);
      rd_ok_s         = ({1'b0, bus.rd_sel} < NUM_CHAN_W) &&
                        !(|(fail_q & chan_onehot(bus.rd_sel)));

      case (state_q)
         S_STARTUP: begin
            if (cnt_q == STARTUP_DELAY) begin
               state_d    = S_INIT_START;
               cur_chan_d = 3'd0;
               retry_d    = 4'd0;
            end else begin
               state_d = S_STARTUP;
            end
         end
         S_INIT_START: begin
            state_d = S_INIT_WAIT;
         end
         S_INIT_WAIT: begin
            // Done is checked first so it wins over a coincident timeout.
            if ((cnt_q >= SETTLE_DELAY) && init_done_sel_s) begin
               state_d = S_NEXT;
            end else if (cnt_q == INIT_TIMEOUT) begin
               if (retry_q < MAX_RETRY) begin
                  retry_d = retry_q + 4'd1;
                  state_d = S_INIT_START;
               end else begin
                  fail_d  = fail_q | cur_oh_s;
                  state_d = S_NEXT;
               end
            end else begin
               state_d = S_INIT_WAIT;
            end
         end
         S_NEXT: begin
            if (cur_chan_q == LAST_CHAN) begin
               state_d = S_READY;
            end else begin
               cur_chan_d = cur_chan_q + 3'd1;
               retry_d    = 4'd0;
               state_d    = S_INIT_START;
            end
         end
         S_READY: begin
            if (bus.rd_req && rd_ok_s) begin
               cur_chan_d = bus.rd_sel;
               state_d    = S_RD_START;
            end else if (bus.rd_req) begin
               rd_err_d = 1'b1;
            end else begin
               state_d = S_READY;
            end
         end
         S_RD_START: begin
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (rd_done_sel_s) begin
               state_d = S_READY;
            end else if (cnt_q == RD_TIMEOUT) begin
               rd_err_d = 1'b1;
               state_d  = S_READY;
            end else begin
               state_d = S_RD_WAIT;
            end
         end
         default: begin
            state_d = S_STARTUP;
         end
      endcase

      // A tick coinciding with a state change is intentionally lost.
      if (state_d != state_q) begin
         cnt_d = 32'd0;
      end else begin
         cnt_d = cnt_q + {31'd0, tick_1us};
      end

      if (state_d == S_INIT_START) begin
         init_start_d = chan_onehot(cur_chan_d);
      end else begin
         init_start_d = '0;
      end

      if (state_d == S_RD_START) begin
         rd_start_d = chan_onehot(cur_chan_d);
      end else begin
         rd_start_d = '0;
      end

      busy_d      = (state_d != S_READY);
      all_ready_d = (state_d == S_READY) && !(|fail_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_STARTUP;
         cnt_q        <= 32'd0;
         cur_chan_q   <= 3'd0;
         retry_q      <= 4'd0;
         fail_q       <= '0;
         init_start_q <= '0;
         rd_start_q   <= '0;
         rd_err_q     <= 1'b0;
         busy_q       <= 1'b1;
         all_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_chan_q   <= cur_chan_d;
         retry_q      <= retry_d;
         fail_q       <= fail_d;
         init_start_q <= init_start_d;
         rd_start_q   <= rd_start_d;
         rd_err_q     <= rd_err_d;
         busy_q       <= busy_d;
         all_ready_q  <= all_ready_d;
      end
   end

   assign bus.init_start = init_start_q;
   assign bus.rd_start   = rd_start_q;
   assign bus.fail       = fail_q;
   assign bus.rd_err     = rd_err_q;
   assign bus.busy       = busy_q;
   assign bus.all_ready  = all_ready_q;
   assign bus.cur_chan   = cur_chan_q;
   assign bus.state_out  = state_q;

endmodule

// File: tb/tb_bringup_sequencer.sv
// Directed bench for bringup_sequencer: behavioural init/read engines plus an event scoreboard
// keyed on microsecond-tick timestamps counted from reset release.
module tb_bringup_sequencer;

   localparam int NCH = 2;

   logic clk;
   logic reset;
   logic tick_1us;
   logic [1:0] div;

   bringup_sequencer_if #(.NUM_CHAN(NCH)) bus ();

   bringup_sequencer #(
      .NUM_CHAN      (NCH),
      .STARTUP_DELAY (32'd5),
      .SETTLE_DELAY  (32'd3),
      .INIT_TIMEOUT  (32'd10),
      .MAX_RETRY     (4'd1),
      .RD_TIMEOUT    (32'd4)
   ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tick_1us (tick_1us),
      .bus      (bus)
   );

   typedef struct {
      int kind;   // 0 init_start, 1 rd_start, 2 rd_err
      int chan;
      int stamp;  // ticks seen since reset release, before the event cycle
   } ev_t;

   ev_t exp_q[$];
   int  total;
   int  bad;
   int  tick_total;

   // init_mode: 0 done 2 ticks after start, 1 done tied high, 2 silent on first attempt, 3 never
   logic [1:0] init_mode [NCH];
   logic       rd_never  [NCH];
   int         rem_i     [NCH];
   int         rem_r     [NCH];
   int         attempt   [NCH];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tick every 4th cycle, phase locked to reset release.
   initial begin
      tick_1us = 1'b0;
      div      = 2'd0;
      forever begin
         @(posedge clk);
         if (reset) div = 2'd0;
         else       div = div + 2'd1;
         #1;
         tick_1us = (div == 2'd3);
      end
   end

   // Init and read engines.
   initial begin
      bus.init_done = '0;
      bus.rd_done   = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int ch = 0; ch < NCH; ch++) begin
            if (reset) begin
               attempt[ch]          = 0;
               rem_i[ch]            = 0;
               rem_r[ch]            = 0;
               bus.init_done[ch]    = (init_mode[ch] == 2'd1);
               bus.rd_done[ch]      = 1'b0;
            end else begin
               if (bus.init_start[ch]) begin
                  attempt[ch] = attempt[ch] + 1;
                  if (init_mode[ch] != 2'd1) begin
                     bus.init_done[ch] = 1'b0;
                     if (init_mode[ch] == 2'd0 || (init_mode[ch] == 2'd2 && attempt[ch] >= 2))
                        rem_i[ch] = 2;
                     else
                        rem_i[ch] = 0;
                  end
               end else if (rem_i[ch] != 0 && tick_1us) begin
                  rem_i[ch] = rem_i[ch] - 1;
                  if (rem_i[ch] == 0) bus.init_done[ch] = 1'b1;
               end
               if (bus.rd_start[ch]) begin
                  bus.rd_done[ch] = 1'b0;
                  rem_r[ch] = rd_never[ch] ? 0 : 2;
               end else if (rem_r[ch] != 0 && tick_1us) begin
                  rem_r[ch] = rem_r[ch] - 1;
                  if (rem_r[ch] == 0) bus.rd_done[ch] = 1'b1;
               end
            end
         end
      end
   end

   task automatic obs(input int kind, input int chan);
      ev_t e;
      total = total + 1;
      if (exp_q.size() == 0) begin
         e.kind = -1; e.chan = -1; e.stamp = -1;
      end else begin
         e = exp_q.pop_front();
      end
      assert (kind === e.kind && chan === e.chan && tick_total === e.stamp) else begin
         bad = bad + 1;
         $error("FAIL event got kind=%0d chan=%0d tick=%0d expected kind=%0d chan=%0d tick=%0d",
                kind, chan, tick_total, e.kind, e.chan, e.stamp);
      end
   endtask

   // Output monitor: timestamps pulses and feeds them to the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         tick_total = 0;
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (bus.init_start[ch]) obs(0, ch);
            if (bus.rd_start[ch])   obs(1, ch);
         end
         if (bus.rd_err) obs(2, 0);
         if (tick_1us) tick_total = tick_total + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      assert (got === exp) else begin
         bad = bad + 1;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input int kind, input int chan, input int stamp);
      ev_t e;
      e.kind = kind; e.chan = chan; e.stamp = stamp;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      exp_q.delete();
      @(posedge clk); #3 reset = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      @(negedge clk); #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},      32'(bus.state_out),  32'd1);
      chk({tag, "_busy"},       32'(bus.busy),       32'd1);
      chk({tag, "_all_ready"},  32'(bus.all_ready),  32'd0);
      chk({tag, "_init_start"}, 32'(bus.init_start), 32'd0);
      chk({tag, "_rd_start"},   32'(bus.rd_start),   32'd0);
      chk({tag, "_fail"},       32'(bus.fail),       32'd0);
      chk({tag, "_rd_err"},     32'(bus.rd_err),     32'd0);
      chk({tag, "_cur_chan"},   32'(bus.cur_chan),   32'd0);
   endtask

   task automatic wait_state(input string tag, input logic [3:0] st, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk); #1;
         if (bus.state_out == st) break;
      end
      chk(tag, 32'(bus.state_out), 32'(st));
   endtask

   task automatic wait_tick(output int base);
      base = -1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); #1;
         if (tick_1us) begin
            base = tick_total;
            break;
         end
      end
   endtask

   task automatic pulse_req(input logic [2:0] sel);
      @(posedge clk); #3;
      bus.rd_sel = sel;
      bus.rd_req = 1'b1;
      @(posedge clk); #3;
      bus.rd_req = 1'b0;
   endtask

   task automatic settle_sb(input string tag);
      repeat (3) @(negedge clk);
      #1;
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base;
      int n;
      reset      = 1'b1;
      bus.rd_req = 1'b0;
      bus.rd_sel = 3'd0;
      total      = 0;
      bad        = 0;
      tick_total = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         init_mode[ch] = 2'd0;
         rd_never[ch]  = 1'b0;
      end

      // Nominal bring-up: starts at tick 5 and 8 (done accepted at count 3, not 2).
      do_reset();
      chk_reset_vals("rst");
      push(0, 0, 5); push(0, 1, 8);
      wait_state("nom_ready", 4'd0, 300);
      chk("nom_busy",      32'(bus.busy),      32'd0);
      chk("nom_all_ready", 32'(bus.all_ready), 32'd1);
      chk("nom_fail",      32'(bus.fail),      32'd0);
      settle_sb("nom_sb");

      // Read ch0 answered after 2 ticks.
      wait_tick(base);
      push(1, 0, base);
      pulse_req(3'd0);
      wait_state("rd0_ready", 4'd0, 100);
      settle_sb("rd0_sb");
      chk("rd0_cur_chan", 32'(bus.cur_chan), 32'd0);

      // Out-of-range read.
      wait_tick(base);
      push(2, 0, base);
      pulse_req(3'd5);
      settle_sb("rd5_sb");
      chk("rd5_state", 32'(bus.state_out), 32'd0);

      // Read timeout on ch0.
      rd_never[0] = 1'b1;
      wait_tick(base);
      push(1, 0, base); push(2, 0, base + 4);
      pulse_req(3'd0);
      wait_state("rdto_ready", 4'd0, 100);
      settle_sb("rdto_sb");

      // Early done: ch0 tied high, still accepted only at count 3.
      rd_never[0]  = 1'b0;
      init_mode[0] = 2'd1;
      do_reset();
      push(0, 0, 5); push(0, 1, 8);
      wait_state("early_ready", 4'd0, 300);
      chk("early_all_ready", 32'(bus.all_ready), 32'd1);
      settle_sb("early_sb");

      // Retry then success: ch0 restarted 10 ticks later.
      init_mode[0] = 2'd2;
      do_reset();
      push(0, 0, 5); push(0, 0, 15); push(0, 1, 18);
      wait_state("retry_ready", 4'd0, 400);
      chk("retry_fail",      32'(bus.fail),      32'd0);
      chk("retry_all_ready", 32'(bus.all_ready), 32'd1);
      settle_sb("retry_sb");

      // Exhausted retries on ch1.
      init_mode[0] = 2'd0;
      init_mode[1] = 2'd3;
      do_reset();
      push(0, 0, 5); push(0, 1, 8); push(0, 1, 18);
      wait_state("exh_ready", 4'd0, 500);
      chk("exh_fail",      32'(bus.fail),      32'd2);
      chk("exh_all_ready", 32'(bus.all_ready), 32'd0);
      chk("exh_busy",      32'(bus.busy),      32'd0);
      settle_sb("exh_sb");
      wait_tick(base);
      push(2, 0, base);
      pulse_req(3'd1);
      settle_sb("exh_rd1_sb");
      chk("exh_rd1_state", 32'(bus.state_out), 32'd0);

      // Reset in the middle of ch1 INIT_WAIT.
      init_mode[1] = 2'd0;
      do_reset();
      push(0, 0, 5); push(0, 1, 8);
      n = 0;
      while (n < 300 && !(bus.state_out == 4'd3 && bus.cur_chan == 3'd1)) begin
         @(negedge clk); #1;
         n = n + 1;
      end
      chk("mid_state", 32'(bus.state_out), 32'd3);
      chk("mid_chan",  32'(bus.cur_chan),  32'd1);
      @(posedge clk); #3 reset = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      chk_reset_vals("mid_rst");
      chk("mid_sb", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #3 reset = 1'b0;
      push(0, 0, 5); push(0, 1, 8);
      wait_state("mid_ready", 4'd0, 300);
      chk("mid_all_ready", 32'(bus.all_ready), 32'd1);
      settle_sb("mid_sb_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bringup_sequencer.md
Name: bringup_sequencer

Overview:
- Parametrised power-up and configuration sequencer for N peripheral init engines (ADV7513 HDMI TX, camera sensors, ...), each driven by a start/done handshake.
- Counts microsecond ticks to hold off after power-up, then initialises each channel in order.
- Each init attempt has a settle window, a timeout and a bounded retry count.
- Once the sequence finishes, it services on-demand register-read requests per channel and exposes status for LEDs and 7-segment displays.

Parameters:
NUM_CHAN, 2, number of init/read channels (1..8)
STARTUP_DELAY, 32'd1000000, tick_1us pulses to wait after reset before the first init
SETTLE_DELAY, 32'd1000, minimum ticks after init_start before init_done is accepted
INIT_TIMEOUT, 32'd20000, ticks after init_start with no accepted done before the attempt fails (must be > SETTLE_DELAY)
MAX_RETRY, 4'd2, extra init attempts per channel after the first failure
RD_TIMEOUT, 32'd600, ticks to wait for rd_done before declaring a read error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_1us  in  1  one-clk enable pulse, once per microsecond
init_start  out  NUM_CHAN  one-clk start pulse per channel
init_done  in  NUM_CHAN  level done from each init engine
rd_req  in  1  read request, level-sampled in S_READY
rd_sel  in  3  channel index for the read
rd_start  out  NUM_CHAN  one-clk read start pulse
rd_done  in  NUM_CHAN  level done from each read engine
busy  out  1  high in every state except S_READY
all_ready  out  1  high in S_READY when fail == 0
fail  out  NUM_CHAN  sticky per-channel init failure
rd_err  out  1  one-clk pulse on read timeout or invalid read request
cur_chan  out  3  channel being serviced
state_out  out  4  current state encoding

Behaviour:
- Reset values (clocked, synchronous, active-high):
  - state = S_STARTUP; tick counter = 0; cur_chan = 0; retry count = 0.
  - init_start, rd_start, fail = 0; rd_err = 0; busy = 1; all_ready = 0.
  - Reset asserted mid-operation aborts everything; the sequence restarts from S_STARTUP.
- State encodings: S_READY=0, S_STARTUP=1, S_INIT_START=2, S_INIT_WAIT=3, S_RD_START=4, S_RD_WAIT=5, S_NEXT=6. Unused codes go to S_STARTUP.
- Tick counter: 32-bit, cleared on every state change, incremented on tick_1us otherwise. A tick arriving in the same cycle as a state change is dropped.
- S_STARTUP:
  - Go to S_INIT_START with cur_chan=0 and retry=0 once the count equals STARTUP_DELAY.
- S_INIT_START:
  - init_start[cur_chan]=1 for exactly this one cycle, then S_INIT_WAIT.
- S_INIT_WAIT:
  - init_done[cur_chan] is ignored while the count < SETTLE_DELAY.
  - Count >= SETTLE_DELAY and init_done high: go to S_NEXT.
  - Count == INIT_TIMEOUT with no accepted done: if retry < MAX_RETRY, increment retry and go to S_INIT_START; otherwise set fail[cur_chan]=1 and go to S_NEXT.
  - If done and timeout occur in the same cycle, done wins.
- S_NEXT:
  - If cur_chan == NUM_CHAN-1, go to S_READY.
  - Otherwise increment cur_chan, set retry=0 and go to S_INIT_START.
- S_READY:
  - busy=0; all_ready = ~|fail.
  - On rd_req=1 with rd_sel < NUM_CHAN and fail[rd_sel]=0: cur_chan=rd_sel, go to S_RD_START.
  - On rd_req=1 with rd_sel out of range or the channel failed: rd_err pulses for one cycle and the state stays S_READY.
  - rd_req is level: a held request re-triggers every time the block returns to S_READY.
- S_RD_START:
  - rd_start[cur_chan]=1 for one cycle, then S_RD_WAIT.
- S_RD_WAIT:
  - rd_done[cur_chan]=1: go to S_READY.
  - Count == RD_TIMEOUT: rd_err pulses for one cycle and the state goes to S_READY.
  - rd_done wins over a simultaneous timeout.
- Other channels' init_done/rd_done are ignored at all times.
- init_start and rd_start are never asserted together; at most one bit of either vector is high in any cycle.
- fail is cleared only by reset.

Test Plan:
- Setup: NUM_CHAN=2, STARTUP_DELAY=5, SETTLE_DELAY=3, INIT_TIMEOUT=10, MAX_RETRY=1, RD_TIMEOUT=4, tick_1us every 4 clks.
- Nominal bring-up: both engines raise done 2 ticks after start -> init_start[0] pulses after 5 ticks; done is accepted at tick 3 (not tick 2); init_start[1] follows; S_READY with all_ready=1, fail=2'b00.
- Early done: init_done[0] tied high from reset -> still accepted only once the count reaches 3 after start; no retry.
- Retry then success: ch0 silent on the first attempt and answers on the second -> init_start[0] pulses twice, 10 ticks apart; fail[0]=0.
- Exhausted retries: ch1 never answers -> two attempts, then fail=2'b10, all_ready=0, busy=0; a read with rd_sel=1 gives an rd_err pulse and no rd_start.
- Reads: rd_sel=0 with rd_done after 2 ticks -> one rd_start[0] pulse, back to S_READY; rd_sel=5 -> rd_err pulse; rd_done never arrives -> rd_err after 4 ticks.
- Reset mid-S_INIT_WAIT on ch1 -> all outputs return to reset values next clk; the sequence restarts with a full 5-tick startup wait.
